parse_act_scheduler: RTL and testbench
======================================

# parse_act_scheduler

Sequencer that time-shares one `sub_parser` instance across a list of parse actions for one packet header. It latches a header plus `NUM_ACTS` actions, issues them one per cycle to the sub-parser, and scatters the returned values into a packed PHV of 2B/4B/6B containers. When the PHV is complete it presents it downstream with a valid/ready handshake. The block sits between the packet-header extractor and the first match-action stage.

## Interface
- `PKTS_HDR_LEN`, 32*64+256, header width in bits, passed through to the sub-parser.
- `PARSE_ACT_LEN`, 24, width of one parse action.
- `NUM_ACTS`, 10, number of actions per header (1..16).
- `VAL_OUT_LEN`, 48, sub-parser value width.
- `clk`  in  1  the single clock.
- `rst`  in  1  reset: synchronous to `clk`, active-high.
- `hdr_valid`  in  1  header and action list offered.
- `hdr_ready`  out  1  block can accept a header.
- `pkts_hdr`  in  PKTS_HDR_LEN  packet header bytes.
- `parse_acts`  in  NUM_ACTS*PARSE_ACT_LEN  action list; slot i is at `[i*PARSE_ACT_LEN +: PARSE_ACT_LEN]`.
- `parse_act_valid`  out  1  issue strobe to the sub-parser.
- `parse_act`  out  PARSE_ACT_LEN  action being issued.
- `pkts_hdr_out`  out  PKTS_HDR_LEN  latched header, driven to the sub-parser.
- `val_in_valid`, `val_in[VAL_OUT_LEN]`, `val_in_type[2]`, `val_in_seq[6]`  in  returns from the sub-parser, one cycle after issue.
- `phv_valid`  out  1  PHV complete.
- `phv_ready`  in  1  downstream accepts the PHV.
- `phv_out`  out  768  packed containers: c6[7:0] at [767:384], c4[7:0] at [383:128], c2[7:0] at [127:0]; index 0 is the LSB slot of each group.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- **IDLE**
  - `hdr_ready`=1.
  - On `hdr_valid`, latch the header and actions, clear all PHV containers to 0, and compute the issue list.
  - Go to ISSUE, or to DRAIN if the issue list is empty.
- **ISSUE**
  - Each cycle, drive the next listed slot on `parse_act` with `parse_act_valid`=1.
  - After the last listed slot, go to DRAIN.
- **DRAIN**: one cycle to capture the final return, then go to OUTPUT.
- **OUTPUT**
  - `phv_valid`=1 and `phv_out` stable.
  - On `phv_ready`, go to IDLE.
- **Capture** applies in any state when `val_in_valid`=1, with idx=`val_in_seq[2:0]`:
  - type 01: c2[idx] <= `val_in[15:0]`.
  - type 10: c4[idx] <= `val_in[31:0]`.
  - type 11: c6[idx] <= `val_in[47:0]`.
  - type 00: ignored.
- Duplicate idx within one header: the later return overwrites the earlier one.
- `pkts_hdr_out` holds the latched header from accept until the next accept.

## Timing
- Reset values:
  - `hdr_ready`=0 during reset, 1 in the first cycle after reset.
  - `parse_act_valid`=0, `parse_act`=0, `pkts_hdr_out`=0.
  - `phv_valid`=0, `phv_out`=0.
  - State=IDLE.
- Accept happens at edge 0. Issue cycles are 1..K, where K is the issue-list length. Returns arrive in cycles 2..K+1. DRAIN is cycle K+1. `phv_valid` rises in cycle K+2.
- `parse_act_valid` and `parse_act` are registered outputs.
- `hdr_ready`=0 from the accept edge until the cycle after the `phv_valid`&`phv_ready` handshake, so back-to-back headers cost K+3 cycles minimum.
- `phv_valid` holds with `phv_out` unchanged until `phv_ready`.
- A `val_in_valid` arriving outside cycles 2..K+1 is still captured. It is never generated by a correctly connected sub-parser.
- `rst` asserted in any state abandons the operation: next cycle all outputs are at their reset values and state is IDLE; the PHV is discarded.

## Configuration
- `PARSE_SKIP_INVALID_EN` defined:
  - The issue list is only the slots with action bit 0 set, in ascending slot order, so K = popcount of those bits.
  - A header with no valid actions reaches `phv_valid` in cycle 2.
- Not defined:
  - Every slot 0..NUM_ACTS-1 is issued, so K=NUM_ACTS always.
  - Slots with bit 0 clear are still driven with `parse_act_valid`=1; the sub-parser returns type 00 for them and they are ignored.
  - Latency is fixed at NUM_ACTS+2.

## Test plan
- Reset, then one header with slot 0 = 2B at byte offset 0, seq 0, header bytes 0x12,0x34 -> issue in cycle 1, c2[0]=0x3412, `phv_valid` at cycle 12 (macro off).
- Slots 0..2 as 2B/4B/6B actions with seq 1/2/3 -> c2[1], c4[2] and c6[3] hold the addressed bytes; all other containers are 0.
- Two actions targeting c4[5] with values 0xAAAAAAAA then 0x55555555 -> c4[5]=0x55555555.
- `phv_ready` held low for 5 cycles -> `phv_valid` and `phv_out` stable; `hdr_ready`=0 throughout; accept resumes the cycle after `phv_ready`.
- Macro on, only slots 3 and 7 valid -> exactly 2 issue cycles in order 3, 7; `phv_valid` in cycle 4. All slots invalid -> `phv_valid` in cycle 2 with `phv_out`=0.
- `rst` pulsed in cycle 4 of ISSUE -> next cycle `parse_act_valid`=0, `phv_valid`=0, `phv_out`=0; the following header is processed correctly.

Source files
------------

// File: rtl/parse_act_scheduler.sv
// parse_act_scheduler: time-shares one sub_parser across the parse actions of a
// header. Latches a header and NUM_ACTS actions, issues them one per cycle,
// scatters the returned values into 2B/4B/6B PHV containers, then offers the
// packed PHV downstream with a valid/ready handshake.
// Optional build macro PARSE_SKIP_INVALID_EN: when defined only slots whose
// action bit 0 is set are issued; otherwise every slot is issued.
module parse_act_scheduler #(
    parameter int PKTS_HDR_LEN  = 32*64+256,
    parameter int PARSE_ACT_LEN = 24,
    parameter int NUM_ACTS      = 10,
    parameter int VAL_OUT_LEN   = 48
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              hdr_valid,
    output logic                              hdr_ready,
    input  logic [PKTS_HDR_LEN-1:0]           pkts_hdr,
    input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0] parse_acts,
    output logic                              parse_act_valid,
    output logic [PARSE_ACT_LEN-1:0]          parse_act,
    output logic [PKTS_HDR_LEN-1:0]           pkts_hdr_out,
    input  logic                              val_in_valid,
    input  logic [VAL_OUT_LEN-1:0]            val_in,
    input  logic [1:0]                        val_in_type,
    input  logic [5:0]                        val_in_seq,
    output logic                              phv_valid,
    input  logic                              phv_ready,
    output logic [767:0]                      phv_out
);

    // Slot index width; NUM_ACTS is limited to 16.
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     accept;
    logic [NUM_ACTS-1:0]      accept_mask;
    logic [NUM_ACTS-1:0]      pending;
    logic [IDX_W-1:0]         accept_first;
    logic [IDX_W-1:0]         pending_first;
    logic [PARSE_ACT_LEN-1:0] acts_q [NUM_ACTS];
    logic [15:0]              c2_q [8];
    logic [31:0]              c4_q [8];
    logic [47:0]              c6_q [8];
    logic [2:0]               cap_idx;
    logic                     unused_seq_hi;

    // Only the low three sequence bits address a container.
    assign cap_idx       = val_in_seq[2:0];
    assign unused_seq_hi = ^val_in_seq[5:3];

    // Lowest set bit of a slot mask; slots are issued in ascending order.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ACTS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_ACTS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign accept        = (state == IDLE) && hdr_valid;
    assign accept_first  = lowest_set(accept_mask);
    assign pending_first = lowest_set(pending);

    // Build the issue list for the header being offered.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        accept_mask = '1;
`ifdef PARSE_SKIP_INVALID_EN
        for (int i = 0; i < NUM_ACTS; i++) begin
            accept_mask[i] = parse_acts[i*PARSE_ACT_LEN];
        end
`endif
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs at the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        next_state = state;
        hdr_ready  = 1'b0;
        phv_valid  = 1'b0;
        case (state)
            IDLE: begin
                hdr_ready = !rst;
                if (hdr_valid) next_state = (accept_mask != '0) ? ISSUE : DRAIN;
            end
            ISSUE: begin
                if (pending == '0) next_state = DRAIN;
            end
            DRAIN: begin
                next_state = OUTPUT;
            end
            OUTPUT: begin
                phv_valid = 1'b1;
                if (phv_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Action list storage, consulted only while issuing.
    // NOTE: this array carries no reset; it is always rewritten on accept
    // before any entry is read, and leaving it out of reset keeps it a plain
    // register file.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_ACTS; i++) begin
                acts_q[i] <= parse_acts[i*PARSE_ACT_LEN +: PARSE_ACT_LEN];
            end
        end
    end

    // Header latch and registered issue strobe: the first slot is loaded on
    // the accept edge, each following slot on the next ISSUE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkts_hdr_out    <= '0;
            parse_act_valid <= 1'b0;
            parse_act       <= '0;
            pending         <= '0;
        end else begin
            parse_act_valid <= 1'b0;
            parse_act       <= '0;
            if (accept) begin
                pkts_hdr_out <= pkts_hdr;
                pending      <= accept_mask & (accept_mask - NUM_ACTS'(1));
                if (accept_mask != '0) begin
                    parse_act_valid <= 1'b1;
                    parse_act       <= parse_acts[accept_first*PARSE_ACT_LEN +: PARSE_ACT_LEN];
                end
            end else if (state == ISSUE && pending != '0) begin
                parse_act_valid <= 1'b1;
                parse_act       <= acts_q[pending_first];
                pending         <= pending & (pending - NUM_ACTS'(1));
            end
        end
    end

    // PHV containers: cleared on accept, written by any sub-parser return.
    // A return in the accept cycle is applied after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                c2_q[i] <= '0;
                c4_q[i] <= '0;
                c6_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < 8; i++) begin
                    c2_q[i] <= '0;
                    c4_q[i] <= '0;
                    c6_q[i] <= '0;
                end
            end
            if (val_in_valid) begin
                case (val_in_type)
                    2'b01:   c2_q[cap_idx] <= val_in[15:0];
                    2'b10:   c4_q[cap_idx] <= val_in[31:0];
                    2'b11:   c6_q[cap_idx] <= val_in[47:0];
                    default: ;
                endcase
            end
        end
    end

    // Pack containers: c6 on top, then c4, then c2; slot 0 is lowest.
    always_comb begin
        phv_out = '0;
        for (int i = 0; i < 8; i++) begin
            phv_out[i*16 +: 16]        = c2_q[i];
            phv_out[128 + i*32 +: 32]  = c4_q[i];
            phv_out[384 + i*48 +: 48]  = c6_q[i];
        end
    end

endmodule

// File: tb/tb_parse_act_scheduler.sv
// Bench for parse_act_scheduler: a sub-parser stub answers each issue one
// cycle later by extracting header bytes; expected issues and PHVs are queued
// by the driver and compared by an independent monitor.
module tb_parse_act_scheduler;

    localparam int HDR_W = 32*64+256;
    localparam int ACT_W = 24;
    localparam int N     = 10;
    localparam int VW    = 48;
    localparam int PHV_W = 768;

    logic               clk = 1'b0;
    logic               rst;
    logic               hdr_valid;
    logic               hdr_ready;
    logic [HDR_W-1:0]   pkts_hdr;
    logic [N*ACT_W-1:0] parse_acts;
    logic               parse_act_valid;
    logic [ACT_W-1:0]   parse_act;
    logic [HDR_W-1:0]   pkts_hdr_out;
    logic               val_in_valid;
    logic [VW-1:0]      val_in;
    logic [1:0]         val_in_type;
    logic [5:0]         val_in_seq;
    logic               phv_valid;
    logic               phv_ready;
    logic [PHV_W-1:0]   phv_out;

    parse_act_scheduler #(
        .PKTS_HDR_LEN (HDR_W),
        .PARSE_ACT_LEN(ACT_W),
        .NUM_ACTS     (N),
        .VAL_OUT_LEN  (VW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .pkts_hdr       (pkts_hdr),
        .parse_acts     (parse_acts),
        .parse_act_valid(parse_act_valid),
        .parse_act      (parse_act),
        .pkts_hdr_out   (pkts_hdr_out),
        .val_in_valid   (val_in_valid),
        .val_in         (val_in),
        .val_in_type    (val_in_type),
        .val_in_seq     (val_in_seq),
        .phv_valid      (phv_valid),
        .phv_ready      (phv_ready),
        .phv_out        (phv_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACT_W-1:0] act;
        int               due;
    } iss_t;

    typedef struct {
        logic [PHV_W-1:0] phv;
        logic [HDR_W-1:0] hdr;
        int               due;
        int               stall;
    } phv_t;

    iss_t iss_q[$];
    phv_t phv_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   hs_pending = 1'b0;

    logic [ACT_W-1:0] a [N];
    logic [HDR_W-1:0] h;
    logic [PHV_W-1:0] e;

    // Edge counter: at a falling edge, cyc is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PHV_W-1:0] got,
                         input logic [PHV_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Stub action encoding: [0] valid, [2:1] type, [8:3] seq, [15:9] byte offset.
    function automatic logic [ACT_W-1:0] act(input bit v, input logic [1:0] t,
                                             input logic [5:0] s, input logic [6:0] o);
        return {8'h00, o, s, t, v};
    endfunction

    function automatic logic [PHV_W-1:0] put2(input logic [PHV_W-1:0] p, input int i,
                                              input logic [15:0] v);
        p[i*16 +: 16] = v;
        return p;
    endfunction

    function automatic logic [PHV_W-1:0] put4(input logic [PHV_W-1:0] p, input int i,
                                              input logic [31:0] v);
        p[128 + i*32 +: 32] = v;
        return p;
    endfunction

    function automatic logic [PHV_W-1:0] put6(input logic [PHV_W-1:0] p, input int i,
                                              input logic [47:0] v);
        p[384 + i*48 +: 48] = v;
        return p;
    endfunction

    // Sub-parser stub: sample the issue mid-cycle, answer just after the next edge.
    initial begin
        logic          nv;
        logic [1:0]    nt;
        logic [5:0]    ns;
        logic [VW-1:0] nval;
        val_in_valid = 1'b0;
        val_in       = '0;
        val_in_type  = 2'b00;
        val_in_seq   = '0;
        forever begin
            @(negedge clk);
            nv   = parse_act_valid;
            nt   = parse_act[0] ? parse_act[2:1] : 2'b00;
            ns   = parse_act[8:3];
            nval = pkts_hdr_out[parse_act[15:9]*8 +: VW];
            @(posedge clk);
            #1;
            val_in_valid = nv;
            val_in_type  = nt;
            val_in_seq   = ns;
            val_in       = nval;
        end
    end

    // Monitor: checks issues and PHVs against the queues and drives phv_ready.
    initial begin
        iss_t             it;
        phv_t             pe;
        logic [PHV_W-1:0] held;
        int               vcnt;
        int               stall_now;
        bit               seen;
        phv_ready = 1'b0;
        seen      = 1'b0;
        vcnt      = 0;
        stall_now = 0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (hs_pending) begin
                check("hdr_ready_after_handshake", hdr_ready, 1);
                check("phv_valid_after_handshake", phv_valid, 0);
                hs_pending = 1'b0;
            end
            if (parse_act_valid) begin
                check("hdr_ready_during_issue", hdr_ready, 0);
                if (iss_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got parse_act %0h, expected no issue", parse_act);
                end else begin
                    it = iss_q.pop_front();
                    check("parse_act", parse_act, it.act);
                    check("issue_cycle", cyc, it.due);
                end
            end
            if (phv_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    vcnt = 0;
                    if (phv_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_phv: got phv_valid 1, expected 0");
                        stall_now = 0;
                    end else begin
                        pe = phv_q.pop_front();
                        check("phv_out", phv_out, pe.phv);
                        check("phv_valid_cycle", cyc, pe.due);
                        check("pkts_hdr_out", (pkts_hdr_out === pe.hdr), 1);
                        stall_now = pe.stall;
                    end
                    held = phv_out;
                end else begin
                    check("phv_out_stable", phv_out, held);
                end
                check("hdr_ready_during_output", hdr_ready, 0);
                vcnt++;
                phv_ready = (vcnt > stall_now);
                if (phv_ready) begin
                    hs_pending = 1'b1;
                    seen       = 1'b0;
                end
            end else begin
                phv_ready = 1'b0;
                seen      = 1'b0;
            end
        end
    end

    // Offer header h with action list a; queue the expected issues and PHV.
    task automatic send_hdr(input logic [PHV_W-1:0] exp_phv, input int stall);
        int edge_acc;
        int k;
        int w;
        w = 0;
        while (!hdr_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("hdr_ready_before_send", hdr_ready, 1);
        pkts_hdr = h;
        for (int i = 0; i < N; i++) parse_acts[i*ACT_W +: ACT_W] = a[i];
        hdr_valid = 1'b1;
        edge_acc  = cyc + 1;
        k = 0;
        for (int i = 0; i < N; i++) begin
            iss_t it;
            it.act = a[i];
            it.due = edge_acc + k;
`ifdef PARSE_SKIP_INVALID_EN
            if (a[i][0]) begin
                iss_q.push_back(it);
                k++;
            end
`else
            iss_q.push_back(it);
            k++;
`endif
        end
        begin
            phv_t pe;
            pe.phv   = exp_phv;
            pe.hdr   = h;
            pe.due   = edge_acc + k + 1;
            pe.stall = stall;
            phv_q.push_back(pe);
        end
        @(negedge clk);
        #1;
        hdr_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation is consumed and the block is idle.
    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (phv_q.size() == 0 && iss_q.size() == 0 && hdr_ready && !phv_valid)
                done = 1'b1;
        end
        check("completion_within_budget", done, 1);
    endtask

    task automatic clear_acts();
        for (int i = 0; i < N; i++) a[i] = '0;
        h = '0;
    endtask

    // T2 header and action list, reused after the reset test.
    task automatic load_t2();
        clear_acts();
        for (int i = 0; i < 32; i++) h[i*8 +: 8] = 8'hA0 + 8'(i);
        a[0] = act(1'b1, 2'b01, 6'd1, 7'd2);
        a[1] = act(1'b1, 2'b10, 6'd2, 7'd4);
        a[2] = act(1'b1, 2'b11, 6'd3, 7'd10);
        e = '0;
        e = put2(e, 1, 16'hA3A2);
        e = put4(e, 2, 32'hA7A6A5A4);
        e = put6(e, 3, 48'hAFAEADACABAA);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        hdr_valid  = 1'b0;
        pkts_hdr   = '0;
        parse_acts = '0;
        clear_acts();
        e = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("reset_hdr_ready", hdr_ready, 0);
        check("reset_parse_act_valid", parse_act_valid, 0);
        check("reset_parse_act", parse_act, 0);
        check("reset_pkts_hdr_out_zero", (pkts_hdr_out === '0), 1);
        check("reset_phv_valid", phv_valid, 0);
        check("reset_phv_out", phv_out, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("hdr_ready_after_reset", hdr_ready, 1);

        // T1: single 2B action at offset 0, seq 0.
        clear_acts();
        h[7:0]  = 8'h12;
        h[15:8] = 8'h34;
        a[0] = act(1'b1, 2'b01, 6'd0, 7'd0);
        e = put2('0, 0, 16'h3412);
        send_hdr(e, 0);
        wait_done();

        // T2: 2B/4B/6B actions with seq 1/2/3.
        load_t2();
        send_hdr(e, 0);
        wait_done();

        // T3: two writes to c4[5], later one wins; downstream stalls 5 cycles.
        clear_acts();
        for (int i = 0; i < 4; i++) h[i*8 +: 8] = 8'hAA;
        for (int i = 4; i < 8; i++) h[i*8 +: 8] = 8'h55;
        a[0] = act(1'b1, 2'b10, 6'd5, 7'd0);
        a[1] = act(1'b1, 2'b10, 6'd5, 7'd4);
        e = put4('0, 5, 32'h55555555);
        send_hdr(e, 5);
        wait_done();

        // T4: only slots 3 and 7 valid, with invalid decoys elsewhere; seq 8 maps to slot 0.
        clear_acts();
        for (int i = 0; i < 32; i++) h[i*8 +: 8] = 8'h30 + 8'(i);
        a[1] = act(1'b0, 2'b11, 6'd2, 7'd0);
        a[3] = act(1'b1, 2'b01, 6'd6, 7'd0);
        a[5] = act(1'b0, 2'b01, 6'd7, 7'd0);
        a[7] = act(1'b1, 2'b11, 6'd8, 7'd20);
        e = '0;
        e = put2(e, 6, 16'h3130);
        e = put6(e, 0, 48'h494847464544);
        send_hdr(e, 0);
        wait_done();

        // T5: no valid action at all; PHV comes out empty.
        clear_acts();
        for (int i = 0; i < 32; i++) h[i*8 +: 8] = 8'h5A;
        a[0] = act(1'b0, 2'b11, 6'd1, 7'd0);
        a[9] = act(1'b0, 2'b10, 6'd4, 7'd2);
        send_hdr('0, 0);
        wait_done();

        // T6: reset pulsed in issue cycle 4 abandons the header.
        clear_acts();
        for (int i = 0; i < 32; i++) h[i*8 +: 8] = 8'hC0 + 8'(i);
        for (int i = 0; i < 6; i++) a[i] = act(1'b1, 2'b01, 6'(i), 7'(2*i));
        send_hdr('0, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        iss_q.delete();
        phv_q.delete();
        @(negedge clk);
        #1;
        check("rst_mid_parse_act_valid", parse_act_valid, 0);
        check("rst_mid_parse_act", parse_act, 0);
        check("rst_mid_phv_valid", phv_valid, 0);
        check("rst_mid_phv_out", phv_out, 0);
        check("rst_mid_pkts_hdr_out_zero", (pkts_hdr_out === '0), 1);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Following header is processed normally.
        load_t2();
        send_hdr(e, 0);
        wait_done();

        check("issue_queue_empty", iss_q.size(), 0);
        check("phv_queue_empty", phv_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
